// File: rtl/ray_inv_align_fifo.sv
// Ray side-data alignment behind the inverse-direction dividers plus a first-word-fall-through ray FIFO.
// Optional feature macro RAY_INV_DBZ_SAT_EN: divide-by-zero components are stored as the Q18.18 maximum.
package ray_inv_align_pkg;
    typedef struct packed { logic [31:0] z; logic [31:0] y; logic [31:0] x; } vec3;
    typedef struct packed { logic [35:0] z; logic [35:0] y; logic [35:0] x; } vec3_18_18;
endpackage

module ray_inv_align_fifo
    import ray_inv_align_pkg::*;
#(
    parameter int DIV_LATENCY = 41,
    parameter int FIFO_DEPTH  = 8,
    parameter int PIX_ID_W    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  vec3                 ray_orig,
    input  logic [PIX_ID_W-1:0] pix_id,
    input  vec3_18_18           inv_ray_dir,
    input  logic [2:0]          div_by_zero,
    output logic                stall,
    output logic                out_valid,
    input  logic                out_ready,
    output vec3                 out_orig,
    output vec3_18_18           out_inv_dir,
    output logic [PIX_ID_W-1:0] out_pix_id,
    output logic [2:0]          out_dbz,
    output logic [31:0]         ray_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [35:0] INV_SAT = 36'h7_FFFF_FFFF;

    typedef struct packed {
        vec3                 orig;
        logic [PIX_ID_W-1:0] pix_id;
        vec3_18_18           inv_dir;
        logic [2:0]          dbz;
    } rec_t;

    logic                   stall_reg;
    logic                   adv;
    logic [DIV_LATENCY-1:0] dl_valid_reg;
    vec3                    dl_orig_reg [DIV_LATENCY];
    logic [PIX_ID_W-1:0]    dl_pix_reg  [DIV_LATENCY];
    logic [107:0]           inv_raw;
    logic [107:0]           inv_proc;
    rec_t                   mem [FIFO_DEPTH];
    rec_t                   wr_rec;
    rec_t                   head;
    logic [AW-1:0]          wr_ptr_reg;
    logic [AW-1:0]          rd_ptr_reg;
    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          count_next;
    logic [31:0]            ray_count_reg;
    logic                   wr_en;
    logic                   rd_en;

    assign adv = ~stall_reg;

    // Only the valid bits need clearing: stale origins/ids behind a zero valid are never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid_reg <= '0;
        end else if (adv) begin
            dl_valid_reg <= {dl_valid_reg[DIV_LATENCY-2:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            dl_orig_reg[0] <= ray_orig;
            dl_pix_reg[0]  <= pix_id;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                dl_orig_reg[i] <= dl_orig_reg[i-1];
                dl_pix_reg[i]  <= dl_pix_reg[i-1];
            end
        end
    end

    assign inv_raw = inv_ray_dir;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sat
`ifdef RAY_INV_DBZ_SAT_EN
            // Dividend is always +1, so a zero divisor saturates to the positive maximum.
            assign inv_proc[36*gi +: 36] = div_by_zero[gi] ? INV_SAT : inv_raw[36*gi +: 36];
`else
            assign inv_proc[36*gi +: 36] = inv_raw[36*gi +: 36];
`endif
        end
    endgenerate

    always_comb begin
        wr_rec         = '0;
        wr_rec.orig    = dl_orig_reg[DIV_LATENCY-1];
        wr_rec.pix_id  = dl_pix_reg[DIV_LATENCY-1];
        wr_rec.inv_dir = inv_proc;
        wr_rec.dbz     = div_by_zero;
    end

    // A stalled cycle never writes, so the last stage cannot overrun a full FIFO.
    assign wr_en      = adv & dl_valid_reg[DIV_LATENCY-1];
    assign rd_en      = (count_reg != '0) & out_ready;
    assign count_next = count_reg + CW'(wr_en) - CW'(rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            stall_reg     <= 1'b0;
            ray_count_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                ray_count_reg <= ray_count_reg + 32'd1;
            end
            count_reg <= count_next;
            stall_reg <= (count_next == CW'(FIFO_DEPTH));
        end
    end

    assign head        = mem[rd_ptr_reg];
    assign out_valid   = (count_reg != '0);
    assign out_orig    = out_valid ? head.orig    : '0;
    assign out_inv_dir = out_valid ? head.inv_dir : '0;
    assign out_pix_id  = out_valid ? head.pix_id  : '0;
    assign out_dbz     = out_valid ? head.dbz     : '0;
    assign stall       = stall_reg;
    assign ray_count   = ray_count_reg;

endmodule

// File: tb/tb_ray_inv_align_fifo.sv
// Randomized bench for ray_inv_align_fifo: a queue-based model of accepted rays, their arrival
// after DIV_LATENCY advancing cycles, and the FIFO contents predicts every output each cycle.
module tb_ray_inv_align_fifo;
    import ray_inv_align_pkg::*;

    localparam int LAT   = 41;
    localparam int DEPTH = 8;
    localparam int PW    = 20;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    vec3             ray_orig = '0;
    logic [PW-1:0]   pix_id = '0;
    vec3_18_18       inv_ray_dir = '0;
    logic [2:0]      div_by_zero = '0;
    logic            stall;
    logic            out_valid;
    logic            out_ready = 1'b0;
    vec3             out_orig;
    vec3_18_18       out_inv_dir;
    logic [PW-1:0]   out_pix_id;
    logic [2:0]      out_dbz;
    logic [31:0]     ray_count;

    always #5 clk = ~clk;

    ray_inv_align_fifo #(.DIV_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .PIX_ID_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ray_orig(ray_orig), .pix_id(pix_id),
        .inv_ray_dir(inv_ray_dir), .div_by_zero(div_by_zero), .stall(stall),
        .out_valid(out_valid), .out_ready(out_ready), .out_orig(out_orig),
        .out_inv_dir(out_inv_dir), .out_pix_id(out_pix_id), .out_dbz(out_dbz),
        .ray_count(ray_count)
    );

    typedef struct {
        logic [95:0]  orig;
        logic [PW-1:0] pix;
        logic [107:0] inv;
        logic [2:0]   dbz;
        int           rem;
    } ray_t;

    ray_t         inflight[$];
    ray_t         fifo_q[$];
    logic [110:0] div_pipe [LAT];
    bit           stall_m = 1'b0;
    int unsigned  pops_m = 0;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           first_valid_cyc = -1;
    int           last_valid_cyc = -1;
    int           valid_cycles = 0;
    int           stall_cycles = 0;
    int           accepted = 0;
    bit           last_acc = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [107:0] exp_inv(input logic [107:0] raw, input logic [2:0] dbz);
        logic [107:0] r;
        r = raw;
`ifdef RAY_INV_DBZ_SAT_EN
        for (int i = 0; i < 3; i++) if (dbz[i]) r[36*i +: 36] = 36'h7_FFFF_FFFF;
`endif
        return r;
    endfunction

    // One clock: check outputs against the model at the falling edge, drive inputs for the
    // coming rising edge, then advance the model to the state after that edge.
    task automatic step(input bit v, input bit rdy, input logic [PW-1:0] pix,
                        input logic [95:0] orig, input logic [107:0] inv, input logic [2:0] dbz);
        ray_t r;
        bit   adv;
        @(negedge clk);
        check_val("out_valid", out_valid, fifo_q.size() != 0);
        check_val("stall", stall, stall_m);
        check_val("ray_count", ray_count, pops_m);
        if (fifo_q.size() != 0) begin
            check_val("out_orig", out_orig, fifo_q[0].orig);
            check_val("out_pix_id", out_pix_id, fifo_q[0].pix);
            check_val("out_inv_dir", out_inv_dir, fifo_q[0].inv);
            check_val("out_dbz", out_dbz, fifo_q[0].dbz);
        end
        if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
            valid_cycles++;
        end
        if (stall) stall_cycles++;

        in_valid    = v;
        out_ready   = rdy;
        pix_id      = pix;
        ray_orig    = orig;
        inv_ray_dir = div_pipe[LAT-1][110:3];
        div_by_zero = div_pipe[LAT-1][2:0];

        adv = !stall_m;
        if (fifo_q.size() != 0 && rdy) begin
            void'(fifo_q.pop_front());
            pops_m++;
        end
        last_acc = 1'b0;
        if (adv) begin
            foreach (inflight[i]) inflight[i].rem--;
            if (inflight.size() != 0 && inflight[0].rem == 0) begin
                r = inflight.pop_front();
                r.inv = exp_inv(r.inv, r.dbz);
                fifo_q.push_back(r);
            end
            if (v) begin
                r.orig = orig; r.pix = pix; r.inv = inv; r.dbz = dbz; r.rem = LAT;
                inflight.push_back(r);
                accepted++;
                last_acc = 1'b1;
            end
            for (int i = LAT - 1; i > 0; i--) div_pipe[i] = div_pipe[i-1];
            div_pipe[0] = {inv, dbz};
        end
        stall_m = (fifo_q.size() == DEPTH);
        cyc++;
    endtask

    task automatic rstep(input bit v, input bit rdy, input logic [PW-1:0] pix);
        logic [95:0]  orig;
        logic [107:0] inv;
        logic [2:0]   dbz;
        orig = {$urandom, $urandom, $urandom};
        inv  = {12'($urandom), $urandom, $urandom, $urandom};
        dbz  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        step(v, rdy, pix, orig, inv, dbz);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_stall", stall, 1'b0);
        check_val("rst_ray_count", ray_count, 32'd0);
        check_val("rst_out_pix_id", out_pix_id, '0);
        check_val("rst_out_orig", out_orig, '0);
        inflight.delete();
        fifo_q.delete();
        stall_m = 1'b0;
        pops_m = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic clear_stats();
        cyc = 0;
        first_valid_cyc = -1;
        last_valid_cyc = -1;
        valid_cycles = 0;
        stall_cycles = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] pix;
        for (int i = 0; i < LAT; i++) div_pipe[i] = '0;
        apply_reset();

        // Single ray: out_valid only at cycle 42.
        clear_stats();
        step(1'b1, 1'b1, 20'h00005, {32'd3, 32'd2, 32'd1}, {36'd30, 36'd20, 36'd10}, 3'b000);
        for (int i = 0; i < 60; i++) rstep(1'b0, 1'b1, '0);
        check_val("single_first_cyc", first_valid_cyc, 42);
        check_val("single_valid_cycles", valid_cycles, 1);
        check_val("single_ray_count", ray_count, 32'd1);

        // Back-to-back: 20 rays, outputs on cycles 42..61, no stall.
        clear_stats();
        for (int i = 0; i < 20; i++) rstep(1'b1, 1'b1, PW'(i));
        for (int i = 0; i < 60; i++) rstep(1'b0, 1'b1, '0);
        check_val("b2b_first_cyc", first_valid_cyc, 42);
        check_val("b2b_last_cyc", last_valid_cyc, 61);
        check_val("b2b_valid_cycles", valid_cycles, 20);
        check_val("b2b_stall_cycles", stall_cycles, 0);

        // Divide by zero on y.
        step(1'b1, 1'b1, 20'h000D0, {32'd7, 32'd8, 32'd9},
             {36'h0_0000_1234, 36'h0_BAD0_0000, 36'h0_0000_5678}, 3'b010);
        for (int i = 0; i < 50; i++) rstep(1'b0, 1'b1, '0);

        // Backpressure: continuous stream with the consumer blocked; upstream holds the ray.
        clear_stats();
        pix = 20'h00100;
        for (int i = 0; i < 80; i++) begin
            rstep(1'b1, 1'b0, pix);
            if (last_acc) pix++;
        end
        check_val("bp_stall_seen", stall_cycles != 0, 1'b1);
        rstep(1'b1, 1'b1, pix);
        if (last_acc) pix++;
        for (int i = 0; i < 6; i++) begin
            rstep(1'b1, 1'b0, pix);
            if (last_acc) pix++;
        end
        for (int i = 0; i < 120; i++) rstep(1'b0, 1'b1, '0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) rstep($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, PW'($urandom));
        for (int i = 0; i < 120; i++) rstep(1'b0, 1'b1, '0);

        // Reset with 5 rays in flight and 3 in the FIFO.
        for (int i = 0; i < 3; i++) rstep(1'b1, 1'b0, PW'(i));
        for (int i = 0; i < 7; i++) rstep(1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) rstep(1'b1, 1'b0, PW'(i + 3));
        for (int i = 0; i < 100 && fifo_q.size() != 3; i++) rstep(1'b0, 1'b0, '0);
        check_val("pre_rst_out_valid", out_valid, 1'b1);
        apply_reset();
        clear_stats();
        for (int i = 0; i < 100; i++) rstep(1'b0, 1'b1, '0);
        check_val("rst_no_stale", valid_cycles, 0);

        // Wrap: 300 rays through the FIFO.
        accepted = 0;
        for (int i = 0; i < 6000 && pops_m != 300; i++)
            rstep(accepted < 300, $urandom_range(0, 3) != 0, PW'(accepted));
        rstep(1'b0, 1'b0, '0);
        check_val("wrap_ray_count", ray_count, 32'd300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
